// File: rtl/reset_sequencer.sv
// Drives one destination reset pulse (power-on or on req) and waits for the synchronized ack to fall then rise.
// Latency: rst_out_n follows state by one register; ack_in seen SYNC_STAGES+1 edges later. No backpressure: req outside IDLE is dropped.
module reset_sequencer #(
    parameter int HOLD_CYCLES = 16,
    parameter int ACK_TIMEOUT = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic src_clk,
    input  logic src_resetn,
    input  logic req,
    input  logic clear_err,
    input  logic ack_in,
    output logic rst_out_n,
    output logic busy,
    output logic done,
    output logic timeout
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int WAIT_W = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_WAIT_ENTER,
        ST_WAIT_EXIT
    } state_t;

    state_t                   state_q, state_d;
    logic [HOLD_W-1:0]        hold_cnt_q, hold_cnt_d;
    logic [WAIT_W-1:0]        wait_cnt_q, wait_cnt_d;
    logic                     rst_out_n_q, rst_out_n_d;
    logic                     done_q, done_d;
    logic                     timeout_q, timeout_d;
    logic                     timeout_set;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     ack_s;

    // ack_in is asynchronous to src_clk; only the last flop feeds the FSM.
    always_ff @(posedge src_clk or negedge src_resetn) begin
        if (!src_resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    // Reset lands in ASSERT so that a power-on sequence runs without req.
    always_ff @(posedge src_clk or negedge src_resetn) begin
        if (!src_resetn) begin
            state_q     <= ST_ASSERT;
            hold_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            rst_out_n_q <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            rst_out_n_q <= rst_out_n_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        rst_out_n_d = rst_out_n_q;
        done_d      = 1'b0;
        timeout_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d     = ST_ASSERT;
                    hold_cnt_d  = '0;
                    rst_out_n_d = 1'b0;
                end
            end
            ST_ASSERT: begin
                rst_out_n_d = 1'b0;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_WAIT_ENTER;
                    wait_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            // In both wait states the exit test comes first, so it beats expiry.
            ST_WAIT_ENTER: begin
                rst_out_n_d = 1'b0;
                if (!ack_s) begin
                    state_d     = ST_WAIT_EXIT;
                    rst_out_n_d = 1'b1;
                    wait_cnt_d  = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = ST_IDLE;
                    rst_out_n_d = 1'b1;
                    timeout_set = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_WAIT_EXIT: begin
                rst_out_n_d = 1'b1;
                if (ack_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = ST_IDLE;
                    timeout_set = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (timeout_set) begin
            timeout_d = 1'b1;
        end else if (clear_err) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end
    end

    assign rst_out_n = rst_out_n_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign timeout   = timeout_q;

endmodule
